pio_channel_sched: RTL and testbench
====================================

// Module: pio_channel_sched
// PURPOSE
//  CPU-side scheduler for the PIO parallel-port block. Shares the single
//  PIO output channel (addr/data/write-enable) between NREQ requesters and
//  drains the PIO input buffer into a one-entry receive holding register.
//  Sits between on-chip masters (CPU core, debug/monitor engine) and the PIO.
//  Honours the PIO status flags: bit15 = read data invalid, bit14 = output
//  buffer full.
// PARAMETERS
//  NREQ    2   number of write requesters (2..4)
//  ADDR_W  4   PIO port-address width
//  DATA_W  16  CPU data width; PIO status/data word width
// PORTS
//  iClk       in   1              clock
//  iRst       in   1              synchronous reset, active high
//  iReqVld    in   NREQ           requester i has a write pending
//  iReqAddr   in   NREQ*ADDR_W    packed port addresses, req i at [i*ADDR_W +: ADDR_W]
//  iReqData   in   NREQ*DATA_W    packed write data, req i at [i*DATA_W +: DATA_W]
//  oReqGnt    out  NREQ           one-cycle pulse: request i accepted
//  oPioAddr   out  ADDR_W         to PIO iAddr
//  oPioData   out  DATA_W         to PIO iData
//  oPioWEnb   out  1              to PIO iWEnb
//  oPioREnb   out  1              to PIO iREnb
//  iPioStat   in   DATA_W         from PIO oData (status + input byte)
//  oRxVld     out  1              receive byte valid
//  oRxData    out  8              receive byte
//  iRxAck     in   1              consumer takes oRxData
// BEHAVIOUR
//  Reset values: oReqGnt=0, oPioWEnb=0, oPioREnb=0, oPioAddr=0, oPioData=0,
//  oRxVld=0, oRxData=0. FSM returns to IDLE; arbitration pointer resets to 0.
//  Write FSM, all outputs registered:
//   IDLE  : if any iReqVld and iPioStat[14]==0 -> pick winner w, latch
//           addr/data, pulse oReqGnt[w] -> ISSUE. Else stay.
//   ISSUE : oPioWEnb=1 for exactly one cycle -> HOLD.
//   HOLD  : one cycle, no grant; lets PIO BFullOut become visible -> IDLE.
//  - Request-to-PIO-write latency is 2 cycles (grant cycle, then ISSUE).
//  - Requester holds iReqVld/addr/data stable until its oReqGnt pulse;
//    deasserting iReqVld before grant withdraws the request.
//  - iPioStat[14]==1 in IDLE: no grant; wait indefinitely (no timeout).
//  - At most one write every 3 cycles. Never assert oPioWEnb while
//    iPioStat[14]==1 was seen in the granting cycle.
//  Receive path, independent of the write FSM:
//   - iPioStat[15]==0, oRxVld==0, no REnb in the previous cycle:
//     capture iPioStat[7:0] into oRxData, set oRxVld, and pulse oPioREnb
//     in the same cycle.
//   - The cycle after a REnb pulse is blocked, because PIO status lags
//     by one cycle. This prevents a double read.
//   - oRxVld clears on iRxAck. Ack and a new capture never coincide, because
//     capture requires oRxVld==0.
//   - oRxVld==1 with new PIO data: no read; data stays in PIO (back-pressure).
//  - Read and write may be active in the same cycle (separate enables).
//  - iRst mid-transfer: an in-flight grant/write is dropped and a held
//    rx byte is lost. The requester must re-request after reset.
// CONFIGURATION
//  PIO_SCHED_RR_EN defined: round-robin arbitration. The pointer moves to
//   (winner+1) mod NREQ after each grant, and the search starts at the pointer.
//  PIO_SCHED_RR_EN undefined: fixed priority, lowest index wins. The pointer
//   logic is removed.
// TESTING
//  1 reset: hold iRst with iReqVld=all-1 -> all outputs 0, no gnt; release ->
//    gnt[0] 1 cycle later.
//  2 single write: req0 addr=4'h3 data=16'h00A5, stat=0 -> gnt0 at t+1,
//    oPioWEnb=1 with addr 3/data 00A5 at t+2, next grant no earlier than t+4.
//  3 back-pressure: stat[14]=1 for 10 cycles with req1 pending -> no gnt/WEnb;
//    stat[14]->0 -> gnt1 next cycle.
//  4 arbitration: req0 and req1 continuously valid for 4 grants -> RR: 0,1,0,1;
//    without the macro: 0,0,0,0.
//  5 receive: stat=16'h4057 (bit15=0) -> oRxVld=1, oRxData=8'h57, one REnb
//    pulse; hold stat 2 more cycles, no ack -> no further REnb; ack -> oRxVld=0.
//  6 concurrency: rx capture and write ISSUE in the same cycle -> both enables
//    asserted, both transfers correct; iRst during HOLD -> IDLE, oRxVld=0.

Source files
------------

// File: rtl/pio_channel_sched.sv
// pio_channel_sched: shares the PIO output channel between NREQ write requesters
// and drains the PIO input buffer into a one-entry receive holding register.
// Optional feature macro: PIO_SCHED_RR_EN (round-robin arbitration). When it is
// undefined the lowest-index requester always wins.
module pio_channel_sched #(
   parameter int unsigned NREQ   = 2,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 16
) (
   input  logic                   iClk,
   input  logic                   iRst,
   input  logic [NREQ-1:0]        iReqVld,
   input  logic [NREQ*ADDR_W-1:0] iReqAddr,
   input  logic [NREQ*DATA_W-1:0] iReqData,
   output logic [NREQ-1:0]        oReqGnt,
   output logic [ADDR_W-1:0]      oPioAddr,
   output logic [DATA_W-1:0]      oPioData,
   output logic                   oPioWEnb,
   output logic                   oPioREnb,
   input  logic [DATA_W-1:0]      iPioStat,
   output logic                   oRxVld,
   output logic [7:0]             oRxData,
   input  logic                   iRxAck
);

   localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

   state_e              r_state;
   state_e              w_state_d;
   logic [PTR_W-1:0]    w_win;
   logic                w_found;
   logic                w_grant;
   logic [NREQ-1:0]     r_gnt;
   logic [NREQ-1:0]     w_gnt_d;
   logic                r_wenb;
   logic                w_wenb_d;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_data;
   logic                r_rx_vld;
   logic [7:0]          r_rx_data;
   logic                r_renb;
   logic                r_renb_dly;
   logic                w_rx_cap;
   logic                w_unused_stat;

   // Status bits 13:8 carry nothing this block needs.
   assign w_unused_stat = ^iPioStat[13:8];

   // Grant only from IDLE, and only while the PIO output buffer has room.
   assign w_grant = (r_state == StIdle) && w_found && !iPioStat[14];

`ifdef PIO_SCHED_RR_EN
   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W:0]   w_idx;

   // Round-robin search from the pointer; later iterations are nearer the pointer and win.
   always_comb begin
      w_win   = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = int'(NREQ) - 1; k >= 0; k--) begin
         w_idx = {1'b0, r_ptr} + (PTR_W+1)'(k);
         if (w_idx >= (PTR_W+1)'(NREQ)) w_idx = w_idx - (PTR_W+1)'(NREQ);
         if (iReqVld[w_idx[PTR_W-1:0]]) begin
            w_win   = w_idx[PTR_W-1:0];
            w_found = 1'b1;
         end
      end
   end

   // Pointer moves just past the winner after every grant.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_ptr <= '0;
      end else if (w_grant) begin
         r_ptr <= (w_win == PTR_W'(NREQ - 1)) ? '0 : w_win + 1'b1;
      end
   end
`else
   // Fixed priority: lowest valid index wins.
   always_comb begin
      w_win   = '0;
      w_found = 1'b0;
      for (int k = int'(NREQ) - 1; k >= 0; k--) begin
         if (iReqVld[k]) begin
            w_win   = PTR_W'(k);
            w_found = 1'b1;
         end
      end
   end
`endif

   // Write FSM state register.
   always_ff @(posedge iClk) begin
      if (iRst) r_state <= StIdle;
      else      r_state <= w_state_d;
   end

   // Write FSM next state: IDLE -> ISSUE -> HOLD -> IDLE, one write per three cycles.
   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle:  if (w_grant) w_state_d = StIssue;
         StIssue: w_state_d = StHold;
         StHold:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // Write FSM outputs, computed one cycle ahead so they leave the block registered.
   always_comb begin
      w_gnt_d = '0;
      if (w_grant) w_gnt_d[w_win] = 1'b1;
      w_wenb_d = (r_state == StIssue);
   end

   // Registered write-side outputs; addr/data are captured from the winner at grant.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_gnt  <= '0;
         r_wenb <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else begin
         r_gnt  <= w_gnt_d;
         r_wenb <= w_wenb_d;
         if (w_grant) begin
            r_addr <= iReqAddr[w_win*ADDR_W +: ADDR_W];
            r_data <= iReqData[w_win*DATA_W +: DATA_W];
         end
      end
   end

   // PIO status lags a read by a cycle, so the cycle after a REnb pulse never reads.
   assign w_rx_cap = !iPioStat[15] && !r_rx_vld && !r_renb && !r_renb_dly;

   // Receive holding register; capture and REnb pulse appear together.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_rx_vld   <= 1'b0;
         r_rx_data  <= '0;
         r_renb     <= 1'b0;
         r_renb_dly <= 1'b0;
      end else begin
         r_renb     <= w_rx_cap;
         r_renb_dly <= r_renb;
         if (w_rx_cap) begin
            r_rx_vld  <= 1'b1;
            r_rx_data <= iPioStat[7:0];
         end else if (iRxAck && r_rx_vld) begin
            r_rx_vld <= 1'b0;
         end
      end
   end

   assign oReqGnt  = r_gnt;
   assign oPioWEnb = r_wenb;
   assign oPioAddr = r_addr;
   assign oPioData = r_data;
   assign oPioREnb = r_renb;
   assign oRxVld   = r_rx_vld;
   assign oRxData  = r_rx_data;

endmodule

// File: tb/tb_pio_channel_sched.sv
// Self-checking bench for pio_channel_sched: directed scenarios plus randomized
// traffic, all compared against a cycle-level reference model of the scheduler.
module tb_pio_channel_sched;

   localparam int unsigned NREQ   = 3;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 16;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NREQ-1:0]        vld;
   logic [NREQ*ADDR_W-1:0] addr_bus;
   logic [NREQ*DATA_W-1:0] data_bus;
   logic [NREQ-1:0]        gnt;
   logic [ADDR_W-1:0]      pio_addr;
   logic [DATA_W-1:0]      pio_data;
   logic                   pio_wenb;
   logic                   pio_renb;
   logic [DATA_W-1:0]      stat;
   logic                   rx_vld;
   logic [7:0]             rx_data;
   logic                   ack;

   always #5 clk = ~clk;

   pio_channel_sched #(
      .NREQ   (NREQ),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_dut (
      .iClk     (clk),
      .iRst     (rst),
      .iReqVld  (vld),
      .iReqAddr (addr_bus),
      .iReqData (data_bus),
      .oReqGnt  (gnt),
      .oPioAddr (pio_addr),
      .oPioData (pio_data),
      .oPioWEnb (pio_wenb),
      .oPioREnb (pio_renb),
      .iPioStat (stat),
      .oRxVld   (rx_vld),
      .oRxData  (rx_data),
      .iRxAck   (ack)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Requester side of the bench.
   bit                rp [NREQ];
   logic [ADDR_W-1:0] ra [NREQ];
   logic [DATA_W-1:0] rd [NREQ];

   // Reference model: expected outputs after the coming clock edge.
   logic [NREQ-1:0]   m_gnt;
   logic              m_wenb;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   int                m_since;   // edges since last grant, saturating at 2
   int                m_ptr;
   logic              m_rx_vld;
   logic [7:0]        m_rx_data;
   logic              m_renb;
   logic              m_renb_prev;

   task automatic pack_inputs();
      for (int i = 0; i < NREQ; i++) begin
         vld[i]                       = rp[i];
         addr_bus[i*ADDR_W +: ADDR_W] = ra[i];
         data_bus[i*DATA_W +: DATA_W] = rd[i];
      end
   endtask

   task automatic model_step();
      int   w;
      logic nw;
      logic cap;
      if (rst) begin
         m_gnt = '0; m_wenb = 1'b0; m_addr = '0; m_data = '0;
         m_since = 2; m_ptr = 0;
         m_rx_vld = 1'b0; m_rx_data = '0; m_renb = 1'b0; m_renb_prev = 1'b0;
      end else begin
         nw    = (m_since == 0);
         m_gnt = '0;
         if (m_since >= 2 && (|vld) && !stat[14]) begin
            w = -1;
`ifdef PIO_SCHED_RR_EN
            for (int k = 0; k < NREQ; k++) begin
               int idx;
               idx = (m_ptr + k) % NREQ;
               if (w < 0 && vld[idx]) w = idx;
            end
            m_ptr = (w + 1) % NREQ;
`else
            for (int k = 0; k < NREQ; k++) if (w < 0 && vld[k]) w = k;
`endif
            m_gnt[w] = 1'b1;
            m_addr   = addr_bus[w*ADDR_W +: ADDR_W];
            m_data   = data_bus[w*DATA_W +: DATA_W];
            m_since  = 0;
         end else if (m_since < 2) begin
            m_since++;
         end
         m_wenb = nw;
         cap = !stat[15] && !m_rx_vld && !m_renb && !m_renb_prev;
         m_renb_prev = m_renb;
         m_renb      = cap;
         if (cap) begin
            m_rx_vld  = 1'b1;
            m_rx_data = stat[7:0];
         end else if (ack && m_rx_vld) begin
            m_rx_vld = 1'b0;
         end
      end
   endtask

   // Inputs are already driven; advance one cycle and compare everything.
   task automatic step_and_check();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check("gnt",     gnt,      m_gnt);
      check("wenb",    pio_wenb, m_wenb);
      check("addr",    pio_addr, m_addr);
      check("data",    pio_data, m_data);
      check("renb",    pio_renb, m_renb);
      check("rx_vld",  rx_vld,   m_rx_vld);
      check("rx_data", rx_data,  m_rx_data);
   endtask

   task automatic drop_granted();
      for (int i = 0; i < NREQ; i++) if (m_gnt[i]) rp[i] = 1'b0;
   endtask

   task automatic update_reqs(input int p_new);
      for (int i = 0; i < NREQ; i++) begin
         if (m_gnt[i]) rp[i] = 1'b0;
         if (!rp[i] && $urandom_range(0, 99) < p_new) begin
            rp[i] = 1'b1;
            ra[i] = ADDR_W'($urandom);
            rd[i] = DATA_W'($urandom);
         end else if (rp[i] && !m_gnt[i] && $urandom_range(0, 31) == 0) begin
            rp[i] = 1'b0;
         end
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         drop_granted();
         for (int i = 0; i < NREQ; i++) rp[i] = 1'b0;
         pack_inputs();
         step_and_check();
      end
   endtask

   int exp_arb [4];
   int got_arb [4];
   int n_arb;
   int last_gnt_cyc;

   initial begin
      rst  = 1'b1;
      ack  = 1'b0;
      stat = 16'h8000;
      for (int i = 0; i < NREQ; i++) begin
         rp[i] = 1'b1;
         ra[i] = ADDR_W'(i + 1);
         rd[i] = DATA_W'(16'h1000 + i);
      end
      pack_inputs();

      // Reset held with every request valid.
      for (int c = 0; c < 4; c++) step_and_check();
      rst = 1'b0;
      step_and_check();
      check("rst_release_gnt0", gnt, 1);
      idle_cycles(4);

      // Arbitration order with req0 and req1 continuously valid, from a fresh reset.
      rst = 1'b1;
      step_and_check();
      rst = 1'b0;
`ifdef PIO_SCHED_RR_EN
      exp_arb = '{0, 1, 0, 1};
`else
      exp_arb = '{0, 0, 0, 0};
`endif
      n_arb = 0;
      last_gnt_cyc = -10;
      rp[0] = 1'b1; rp[1] = 1'b1; rp[2] = 1'b0;
      for (int c = 0; c < 40 && n_arb < 4; c++) begin
         pack_inputs();
         step_and_check();
         if (gnt != '0) begin
            for (int i = 0; i < NREQ; i++) if (gnt[i]) got_arb[n_arb] = i;
            check("gnt_gap_ok", (c - last_gnt_cyc) >= 3, 1);
            last_gnt_cyc = c;
            n_arb++;
            for (int i = 0; i < 2; i++) if (gnt[i]) rd[i] = DATA_W'($urandom);
         end
      end
      check("arb_grants", n_arb, 4);
      for (int i = 0; i < 4 && i < n_arb; i++) check("arb_order", got_arb[i], exp_arb[i]);
      idle_cycles(4);

      // Back-pressure: buffer full for 10 cycles with req1 pending.
      rp[1] = 1'b1; ra[1] = 4'h9; rd[1] = 16'hBEEF;
      stat  = 16'hC000;
      for (int c = 0; c < 10; c++) begin
         pack_inputs();
         step_and_check();
         check("bp_no_gnt", gnt, 0);
      end
      stat = 16'h8000;
      step_and_check();
      check("bp_release_gnt1", gnt, 3'b010);
      idle_cycles(4);

      // Receive with back-pressure on the holding register.
      stat = 16'h4057;
      step_and_check();
      check("rx_cap_vld", rx_vld, 1);
      check("rx_cap_data", rx_data, 8'h57);
      check("rx_cap_renb", pio_renb, 1);
      for (int c = 0; c < 2; c++) begin
         step_and_check();
         check("rx_hold_no_renb", pio_renb, 0);
      end
      ack = 1'b1;
      step_and_check();
      check("rx_ack_clear", rx_vld, 0);
      ack  = 1'b0;
      stat = 16'h8000;
      idle_cycles(4);

      // Concurrent read and write, then reset in HOLD.
      rp[0] = 1'b1; ra[0] = 4'h5; rd[0] = 16'h1234;
      pack_inputs();
      step_and_check();
      check("cc_gnt0", gnt, 1);
      rp[0] = 1'b0;
      pack_inputs();
      stat = 16'h0033;
      step_and_check();
      check("cc_wenb", pio_wenb, 1);
      check("cc_renb", pio_renb, 1);
      check("cc_addr", pio_addr, 4'h5);
      check("cc_data", pio_data, 16'h1234);
      check("cc_rxdata", rx_data, 8'h33);
      rst  = 1'b1;
      stat = 16'h8000;
      step_and_check();
      check("hold_rst_rxvld", rx_vld, 0);
      check("hold_rst_wenb", pio_wenb, 0);
      rst   = 1'b0;
      rp[1] = 1'b1; ra[1] = 4'hA; rd[1] = 16'h5A5A;
      pack_inputs();
      step_and_check();
      check("post_rst_gnt1", gnt, 3'b010);

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 800; c++) begin
         update_reqs(30);
         stat = DATA_W'($urandom);
         stat[14] = ($urandom_range(0, 3) == 0);
         ack = ($urandom_range(0, 2) == 0);
         rst = ($urandom_range(0, 199) == 0);
         pack_inputs();
         step_and_check();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
